pla_sweep_checker: RTL
======================

PLA_SWEEP_CHECKER -- requirements
Module: pla_sweep_checker

Interface
REQ-001 Parameter LAST_VEC, default 4095: final 12-bit input vector of the sweep; the sweep always starts at 0.
REQ-002 Parameter SIG_POLY, default 16'h1021: feedback polynomial of the signature register.
REQ-003 Parameter SIG_SEED, default 16'h0000: signature value loaded at sweep start.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a sweep; sampled only in IDLE or DONE.
REQ-007 hold  input  1  stall; while high in SWEEP, no vector is consumed and all state is frozen.
REQ-008 exp_sig  input  16  expected final signature; compared at sweep end.
REQ-009 x_out  output  12  registered vector driving the PLA inputs x0..x11 (bit i drives xi).
REQ-010 y_in  input  1  combinational PLA output y0 for the current x_out.
REQ-011 busy  output  1  high while in SWEEP.
REQ-012 done  output  1  high while in DONE.
REQ-013 signature  output  16  running signature register.
REQ-014 ones_count  output  13  number of consumed vectors with y_in=1.
REQ-015 pass  output  1  registered result of signature==exp_sig, valid while done=1.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SWEEP, DONE.
REQ-017 In IDLE with start=1, the FSM SHALL move to SWEEP, load x_out=0, load signature=SIG_SEED, clear ones_count, and clear pass.
REQ-018 In SWEEP with hold=0, each cycle SHALL consume y_in for the current x_out.
- signature <= {signature[14:0],1'b0} ^ (signature[15] ? SIG_POLY : 0) ^ {15'b0,y_in}.
- ones_count <= ones_count + y_in.
REQ-019 In SWEEP with hold=0 and x_out!=LAST_VEC, x_out SHALL increment by 1 in the same cycle.
REQ-020 In SWEEP with hold=0 and x_out==LAST_VEC, the FSM SHALL consume the final vector, hold x_out at LAST_VEC, enter DONE, and register pass using the updated signature.
REQ-021 With hold=0 throughout, done SHALL rise exactly LAST_VEC+1 cycles after the cycle in which start was sampled.
REQ-022 start asserted during SWEEP SHALL be ignored.
REQ-023 In DONE, signature, ones_count, x_out and pass SHALL hold their values.
REQ-024 In DONE with start=1, the block SHALL restart exactly as in REQ-017, with done falling on the next edge.
REQ-025 hold in IDLE or DONE SHALL have no effect.
REQ-026 If start and hold are both high in IDLE, the transition to SWEEP SHALL still occur; hold applies only from the first SWEEP cycle.
REQ-027 ones_count SHALL NOT saturate; 13 bits cover the maximum value of 4096.
REQ-028 The block SHALL add no combinational path from y_in to any output.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously set: state=IDLE, x_out=0, signature=SIG_SEED, ones_count=0, busy=0, done=0, pass=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately with no partial result retained.
REQ-031 After rst_n is deasserted, the block SHALL remain in IDLE until start is sampled.

Verification
REQ-032 LAST_VEC=3, SEED=0, y_in tied 1, pulse start -> busy high 4 cycles, then done=1, signature=16'h000F, ones_count=4, and pass=1 when exp_sig=16'h000F.
REQ-033 Defaults, y_in tied 0, pulse start -> done 4096 cycles after start, signature=0, ones_count=0, x_out=12'hFFF; pass=0 when exp_sig=16'h0001.
REQ-034 LAST_VEC=3, y_in=1, hold high for 5 cycles after the second vector -> done arrives 9 cycles after start, with the same signature 16'h000F and ones_count=4 as REQ-032.
REQ-035 Pulse rst_n low during SWEEP at x_out=100 -> all outputs at reset values asynchronously; start is then required to begin a new sweep from x_out=0.
REQ-036 Second start pulse while in DONE, and a start pulse mid-sweep -> the DONE start restarts cleanly with count and signature reloaded; the mid-sweep start does not alter x_out progression or results.

Source files
------------

// File: rtl/pla_sweep_checker.sv
// pla_sweep_checker: drives an exhaustive 12-bit input sweep into a single-output
// PLA, compresses each y response into a 16-bit signature, counts the ones and
// compares the final signature against an expected value.
module pla_sweep_checker #(
    parameter logic [11:0] LAST_VEC = 12'd4095,
    parameter logic [15:0] SIG_POLY = 16'h1021,
    parameter logic [15:0] SIG_SEED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic [15:0] exp_sig,
    output logic [11:0] x_out,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [12:0] ones_count,
    output logic        pass
);

    localparam int unsigned XW = 12;
    localparam int unsigned SW = 16;
    localparam int unsigned CW = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [SW-1:0]   sig_q, sig_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic            pass_q, pass_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SW-1:0]   sig_next;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        sig_d    = sig_q;
        ones_d   = ones_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = done_q;
        sig_next = {sig_q[SW-2:0], 1'b0}
                 ^ (sig_q[SW-1] ? SIG_POLY : SW'(0))
                 ^ SW'(y_in);

        case (state_q)
            IDLE, DONE: begin
                // start wins over hold here; hold is only honoured inside SWEEP
                if (start) begin
                    state_d = SWEEP;
                    x_d     = '0;
                    sig_d   = SIG_SEED;
                    ones_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            SWEEP: begin
                if (!hold) begin
                    sig_d  = sig_next;
                    ones_d = ones_q + CW'(y_in);
                    if (x_q == LAST_VEC) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_next == exp_sig);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            sig_q   <= SIG_SEED;
            ones_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            sig_q   <= sig_d;
            ones_q  <= ones_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_out      = x_q;
    assign signature  = sig_q;
    assign ones_count = ones_q;
    assign pass       = pass_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
